pipe_ctrl: RTL and testbench

- Pipeline sequencing controller for the IF / IF_ID / ID / ID_EX / EX datapath.
- Detects load-use hazards between the instruction in ID and a load in EX.
- Stalls the front end while a load waits on data memory.
- Turns an EX-stage jump or taken branch into a PC redirect plus pipeline flushes, and keeps a stall-cycle performance counter and a sticky memory-timeout flag.

---
 rtl/riscv_defs_pkg.sv | 30 +++
 rtl/pipe_ctrl_if.sv | 41 ++++
 rtl/pipe_ctrl_hazard_detect.sv | 27 ++
 rtl/pipe_ctrl.sv | 141 ++++++++++++++
 tb/tb_pipe_ctrl.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/riscv_defs_pkg.sv
// Shared RISC-V pipeline definitions: operation codes, NOP encoding and the
// pipeline controller state encoding.
package riscv_defs_pkg;

    localparam int unsigned OH_W    = 7;
    localparam int unsigned REG_A_W = 5;
    localparam int unsigned XLEN    = 32;

    // Operation codes carried down the pipeline (load subset is 11..15)
    localparam logic [OH_W-1:0] OH_NOP = 7'd0;
    localparam logic [OH_W-1:0] OH_LB  = 7'd11;
    localparam logic [OH_W-1:0] OH_LH  = 7'd12;
    localparam logic [OH_W-1:0] OH_LW  = 7'd13;
    localparam logic [OH_W-1:0] OH_LBU = 7'd14;
    localparam logic [OH_W-1:0] OH_LHU = 7'd15;

    // All-zero instruction word loaded into IF_ID on a flush
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } pipe_state_e;

    // True for any of the five load operation codes
    function automatic logic is_load(input logic [OH_W-1:0] oh);
        return (oh >= OH_LB) && (oh <= OH_LHU);
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Pipeline controller bus: hazard/jump inputs from ID/EX/MEM and the
// sequencing outputs back to the PC and pipeline registers.
//   slave  : controller side (observes pipeline, drives holds/flushes)
//   master : pipeline side
interface pipe_ctrl_if;
    import riscv_defs_pkg::*;

    logic [REG_A_W-1:0] id_rs1_addr;
    logic [REG_A_W-1:0] id_rs2_addr;
    logic [OH_W-1:0]    ex_oh;
    logic [REG_A_W-1:0] ex_rd_addr;
    logic               ex_rd_wen;
    logic               ex_jump_en;
    logic [XLEN-1:0]    ex_jump_addr;
    logic               dmem_ready;

    logic               jump_en;
    logic [XLEN-1:0]    jump_addr;
    logic               pc_hold;
    logic               if_id_hold;
    logic               id_ex_hold;
    logic               if_id_flush;
    logic               id_ex_flush;
    logic               mem_timeout;
    logic [XLEN-1:0]    stall_cycles;

    modport slave (
        input  id_rs1_addr, id_rs2_addr, ex_oh, ex_rd_addr, ex_rd_wen,
               ex_jump_en, ex_jump_addr, dmem_ready,
        output jump_en, jump_addr, pc_hold, if_id_hold, id_ex_hold,
               if_id_flush, id_ex_flush, mem_timeout, stall_cycles
    );

    modport master (
        output id_rs1_addr, id_rs2_addr, ex_oh, ex_rd_addr, ex_rd_wen,
               ex_jump_en, ex_jump_addr, dmem_ready,
        input  jump_en, jump_addr, pc_hold, if_id_hold, id_ex_hold,
               if_id_flush, id_ex_flush, mem_timeout, stall_cycles
    );

endinterface

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use hazard comparator between the ID source registers and the
// destination of a load in EX. Purely combinational.
//   ex_load_i, ex_rd_wen_i, ex_rd_addr_i : EX load descriptor
//   id_rs1_addr_i, id_rs2_addr_i         : ID sources (0 = unused)
//   lu_hazard_o                          : ID needs the loading register
module hazard_detect
    import riscv_defs_pkg::*;
(
    input  logic               ex_load_i,
    input  logic               ex_rd_wen_i,
    input  logic [REG_A_W-1:0] ex_rd_addr_i,
    input  logic [REG_A_W-1:0] id_rs1_addr_i,
    input  logic [REG_A_W-1:0] id_rs2_addr_i,
    output logic               lu_hazard_o
);

    logic rs1_hit;
    logic rs2_hit;

    // x0 never creates a dependency on either side
    assign rs1_hit = (id_rs1_addr_i != '0) && (id_rs1_addr_i == ex_rd_addr_i);
    assign rs2_hit = (id_rs2_addr_i != '0) && (id_rs2_addr_i == ex_rd_addr_i);

    assign lu_hazard_o = ex_load_i && ex_rd_wen_i && (ex_rd_addr_i != '0)
                         && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: load-use bubbles, data-memory wait stalls
// with timeout, EX jump redirect/flush, stall-cycle counter.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : pipe_ctrl_if.slave (pipeline inputs, hold/flush/jump outputs,
//                mem_timeout and stall_cycles status)
module pipe_ctrl
    import riscv_defs_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    pipe_ctrl_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    pipe_state_e        state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               tout_q, tout_d;
    logic [XLEN-1:0]    stall_q, stall_d;

    logic               ex_load;
    logic               lu_hazard;

    logic               jump_en_c;
    logic [XLEN-1:0]    jump_addr_c;
    logic               pc_hold_c;
    logic               if_id_hold_c;
    logic               id_ex_hold_c;
    logic               if_id_flush_c;
    logic               id_ex_flush_c;

    assign ex_load = is_load(bus.ex_oh);

    hazard_detect u_hazard_detect (
        .ex_load_i     (ex_load),
        .ex_rd_wen_i   (bus.ex_rd_wen),
        .ex_rd_addr_i  (bus.ex_rd_addr),
        .id_rs1_addr_i (bus.id_rs1_addr),
        .id_rs2_addr_i (bus.id_rs2_addr),
        .lu_hazard_o   (lu_hazard)
    );

    // Next state and zero-latency control outputs
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        tout_d        = tout_q;
        jump_en_c     = 1'b0;
        jump_addr_c   = '0;
        pc_hold_c     = 1'b0;
        if_id_hold_c  = 1'b0;
        id_ex_hold_c  = 1'b0;
        if_id_flush_c = 1'b0;
        id_ex_flush_c = 1'b0;

        if (rst_n) begin
            unique case (state_q)
                RUN: begin
                    if (bus.ex_jump_en) begin
                        jump_en_c     = 1'b1;
                        jump_addr_c   = bus.ex_jump_addr;
                        if_id_flush_c = 1'b1;
                        id_ex_flush_c = 1'b1;
                    end else if (ex_load && !bus.dmem_ready) begin
                        pc_hold_c    = 1'b1;
                        if_id_hold_c = 1'b1;
                        id_ex_hold_c = 1'b1;
                        state_d      = MEM_WAIT;
                        cnt_d        = CNT_ONE;
                    end else if (lu_hazard) begin
                        pc_hold_c     = 1'b1;
                        if_id_hold_c  = 1'b1;
                        id_ex_flush_c = 1'b1;
                    end
                end
                MEM_WAIT: begin
                    // EX is frozen on a load, so ex_jump_en is not looked at
                    if (bus.dmem_ready) begin
                        if (lu_hazard) begin
                            pc_hold_c     = 1'b1;
                            if_id_hold_c  = 1'b1;
                            id_ex_flush_c = 1'b1;
                        end
                        state_d = RUN;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        // Abandon the load: bubble replaces it in EX
                        pc_hold_c     = 1'b1;
                        if_id_hold_c  = 1'b1;
                        id_ex_flush_c = 1'b1;
                        tout_d        = 1'b1;
                        state_d       = RUN;
                        cnt_d         = '0;
                    end else begin
                        pc_hold_c    = 1'b1;
                        if_id_hold_c = 1'b1;
                        id_ex_hold_c = 1'b1;
                        cnt_d        = cnt_q + CNT_ONE;
                    end
                end
                default: state_d = RUN;
            endcase
        end

        // Saturating stall counter
        stall_d = stall_q;
        if (pc_hold_c && (stall_q != '1)) begin
            stall_d = stall_q + XLEN'(1);
        end
    end

    // State and status registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RUN;
            cnt_q   <= '0;
            tout_q  <= 1'b0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tout_q  <= tout_d;
            stall_q <= stall_d;
        end
    end

    assign bus.jump_en      = jump_en_c;
    assign bus.jump_addr    = jump_addr_c;
    assign bus.pc_hold      = pc_hold_c;
    assign bus.if_id_hold   = if_id_hold_c;
    assign bus.id_ex_hold   = id_ex_hold_c;
    assign bus.if_id_flush  = if_id_flush_c;
    assign bus.id_ex_flush  = id_ex_flush_c;
    assign bus.mem_timeout  = tout_q;
    assign bus.stall_cycles = stall_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl (MEM_TIMEOUT = 4).
module tb_pipe_ctrl;

    // Control vector: {jump_en, pc_hold, if_id_hold, id_ex_hold, if_id_flush, id_ex_flush}
    localparam logic [5:0] C_NONE   = 6'b000000;
    localparam logic [5:0] C_HOLD3  = 6'b011100;
    localparam logic [5:0] C_BUBBLE = 6'b011001;
    localparam logic [5:0] C_JUMP   = 6'b100011;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    pipe_ctrl_if bus ();

    pipe_ctrl #(
        .MEM_TIMEOUT (4),
        .CNT_W       (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [5:0] ctl();
        return {bus.jump_en, bus.pc_hold, bus.if_id_hold, bus.id_ex_hold,
                bus.if_id_flush, bus.id_ex_flush};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [6:0] oh, input logic [4:0] rd, input logic wen,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic rdy,
                         input logic jmp, input logic [31:0] jaddr);
        bus.ex_oh        = oh;
        bus.ex_rd_addr   = rd;
        bus.ex_rd_wen    = wen;
        bus.id_rs1_addr  = rs1;
        bus.id_rs2_addr  = rs2;
        bus.dmem_ready   = rdy;
        bus.ex_jump_en   = jmp;
        bus.ex_jump_addr = jaddr;
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        drive(7'd0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 32'h0);
        tick();
        tick();

        // Reset state
        chk("rst_ctl", 32'(ctl()), 32'(C_NONE));
        chk("rst_stall", bus.stall_cycles, 32'd0);
        chk("rst_tout", 32'(bus.mem_timeout), 32'd0);
        rst_n = 1'b1;
        tick();

        // Load-use: LW rd=5, ID rs1=5, data ready -> one bubble
        drive(7'd13, 5'd5, 1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 32'h0);
        chk("lu_ctl", 32'(ctl()), 32'(C_BUBBLE));
        tick();
        drive(7'd0, 5'd0, 1'b0, 5'd5, 5'd0, 1'b1, 1'b0, 32'h0);
        chk("lu_after", 32'(ctl()), 32'(C_NONE));
        chk("lu_stall", bus.stall_cycles, 32'd1);

        // x0 destination and source -> no stall
        drive(7'd13, 5'd0, 1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 32'h0);
        chk("x0_ctl", 32'(ctl()), 32'(C_NONE));
        tick();
        chk("x0_stall", bus.stall_cycles, 32'd1);

        // Memory wait: LB rd=7, rs2=7, ready low 3 cycles then high
        drive(7'd11, 5'd7, 1'b1, 5'd0, 5'd7, 1'b0, 1'b0, 32'h0);
        chk("mw_c1", 32'(ctl()), 32'(C_HOLD3));
        tick();
        chk("mw_c2", 32'(ctl()), 32'(C_HOLD3));
        tick();
        chk("mw_c3", 32'(ctl()), 32'(C_HOLD3));
        chk("mw_stall3", bus.stall_cycles, 32'd3);
        tick();
        drive(7'd11, 5'd7, 1'b1, 5'd0, 5'd7, 1'b1, 1'b0, 32'h0);
        chk("mw_bubble", 32'(ctl()), 32'(C_BUBBLE));
        tick();
        drive(7'd0, 5'd0, 1'b0, 5'd0, 5'd7, 1'b1, 1'b0, 32'h0);
        chk("mw_after", 32'(ctl()), 32'(C_NONE));
        chk("mw_stall", bus.stall_cycles, 32'd5);
        chk("mw_tout", 32'(bus.mem_timeout), 32'd0);

        // Jump beats a simultaneous load-use hazard
        drive(7'd13, 5'd5, 1'b1, 5'd5, 5'd0, 1'b1, 1'b1, 32'h0000_0100);
        chk("jmp_ctl", 32'(ctl()), 32'(C_JUMP));
        chk("jmp_addr", bus.jump_addr, 32'h0000_0100);
        // Jump also beats a load waiting on memory
        drive(7'd13, 5'd5, 1'b1, 5'd5, 5'd0, 1'b0, 1'b1, 32'h0000_0100);
        chk("jmp_ld_ctl", 32'(ctl()), 32'(C_JUMP));
        tick();
        drive(7'd0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 32'h0);
        chk("jmp_stall", bus.stall_cycles, 32'd5);
        chk("jmp_addr0", bus.jump_addr, 32'h0);

        // Timeout: LH rd=3, ready never rises; jump ignored while waiting
        drive(7'd12, 5'd3, 1'b1, 5'd3, 5'd0, 1'b0, 1'b0, 32'h0);
        chk("to_c1", 32'(ctl()), 32'(C_HOLD3));
        tick();
        drive(7'd12, 5'd3, 1'b1, 5'd3, 5'd0, 1'b0, 1'b1, 32'h0000_0040);
        chk("to_c2_nojmp", 32'(ctl()), 32'(C_HOLD3));
        tick();
        drive(7'd12, 5'd3, 1'b1, 5'd3, 5'd0, 1'b0, 1'b0, 32'h0);
        chk("to_c3", 32'(ctl()), 32'(C_HOLD3));
        tick();
        chk("to_c4", 32'(ctl()), 32'(C_BUBBLE));
        chk("to_flag_pre", 32'(bus.mem_timeout), 32'd0);
        tick();
        drive(7'd0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 32'h0);
        chk("to_flag", 32'(bus.mem_timeout), 32'd1);
        chk("to_stall", bus.stall_cycles, 32'd9);
        chk("to_after", 32'(ctl()), 32'(C_NONE));
        tick();
        tick();
        chk("to_sticky", 32'(bus.mem_timeout), 32'd1);

        // Reset mid-MEM_WAIT
        drive(7'd13, 5'd3, 1'b1, 5'd3, 5'd0, 1'b0, 1'b0, 32'h0);
        chk("rw_enter", 32'(ctl()), 32'(C_HOLD3));
        tick();
        rst_n = 1'b0;
        drive(7'd13, 5'd3, 1'b1, 5'd3, 5'd0, 1'b0, 1'b1, 32'h0000_0200);
        chk("rw_ctl", 32'(ctl()), 32'(C_NONE));
        chk("rw_addr", bus.jump_addr, 32'h0);
        tick();
        chk("rw_ctl2", 32'(ctl()), 32'(C_NONE));
        chk("rw_stall", bus.stall_cycles, 32'd0);
        chk("rw_tout", 32'(bus.mem_timeout), 32'd0);
        tick();
        rst_n = 1'b1;
        // Back in RUN: a jump is honoured (it would be ignored in MEM_WAIT)
        drive(7'd0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 32'h0000_0200);
        chk("rw_run", 32'(ctl()), 32'(C_JUMP));
        chk("rw_run_addr", bus.jump_addr, 32'h0000_0200);
        tick();
        chk("rw_stall2", bus.stall_cycles, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
